// File: rtl/alnsft_lanes.sv
// Multi-lane alignment shifter with per-lane accumulators.
//
// Two-stage pipeline: S1 holds the accepted command, S2 holds the aligned result.
// All accumulator reads and writes happen when S1 advances into S2, so commands
// commit strictly in order and a LOAD is visible to the very next ALIGN.
//
// Ports:
//   clk        clock, all state on the rising edge
//   reset      synchronous active-low reset
//   in_valid   command present          in_ready   command accepted when both high
//   cmd        0 LOAD, 1 ALIGN, 2 SHIFTACC, 3 CLEAR
//   lane_en    per-lane enable mask
//   acc_in     load data, lane i at [i*ACCW +: ACCW]
//   sft        unsigned right-shift amounts, lane i at [i*SFTW +: SFTW]
//   out_valid  result present           out_ready  result consumed when both high
//   aln        aligned mantissas, lane i at [i*(ACCW+1) +: ACCW+1], sticky in bit 0
//   ovf        per lane: shift amount exceeded ACCW
//   acc_o      current accumulator contents
module alnsft_lanes #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACCW  = 48,
  parameter int unsigned SFTW  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  cmd,
  input  logic [LANES-1:0]            lane_en,
  input  logic [LANES*ACCW-1:0]       acc_in,
  input  logic [LANES*SFTW-1:0]       sft,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*(ACCW+1)-1:0]   aln,
  output logic [LANES-1:0]            ovf,
  output logic [LANES*ACCW-1:0]       acc_o
);

  localparam int unsigned ExtW = ACCW + 1;

  typedef enum logic [1:0] {
    CmdLoad     = 2'd0,
    CmdAlign    = 2'd1,
    CmdShiftAcc = 2'd2,
    CmdClear    = 2'd3
  } cmd_e;

  // S1 command register
  logic                     s1_v_q, s1_v_d;
  cmd_e                     cmd_q, cmd_d;
  logic [LANES-1:0]         en_q, en_d;
  logic [LANES*ACCW-1:0]    acc_in_q, acc_in_d;
  logic [LANES*SFTW-1:0]    sft_q, sft_d;

  // Architectural accumulators
  logic [ACCW-1:0]          acc_q [LANES];
  logic [ACCW-1:0]          acc_d [LANES];

  // S2 result register
  logic                     out_valid_q, out_valid_d;
  logic [LANES*ExtW-1:0]    aln_q, aln_d;
  logic [LANES-1:0]         ovf_q, ovf_d;

  logic                     is_ctl;
  logic                     adv;
  logic                     accept;
  logic                     produce;

  // Returns {ovf, aln} for one lane.
  function automatic logic [ExtW:0] align_lane(input logic [ACCW-1:0] acc,
                                               input logic [SFTW-1:0] amt);
    logic [ExtW-1:0] ext;
    logic [ExtW-1:0] mask;
    int unsigned     amt_w;
    int unsigned     s;
    logic            sticky;
    logic            ovf_b;
    ext    = {acc, 1'b0};
    amt_w  = 32'(amt);
    s      = (amt_w > ExtW) ? ExtW : amt_w;
    // A full-width shift wraps the mask to all ones, so everything goes to sticky.
    mask   = (ExtW'(1) << s) - ExtW'(1);
    sticky = |(ext & mask);
    ovf_b  = (amt_w > ACCW);
    return {ovf_b, (ext >> s) | ExtW'(sticky)};
  endfunction

  // LOAD/CLEAR never produce a result, so they may advance past a stalled S2.
  always_comb begin
    is_ctl   = (cmd_q == CmdLoad) || (cmd_q == CmdClear);
    adv      = s1_v_q && (is_ctl || !out_valid_q || out_ready);
    in_ready = !s1_v_q || adv;
    accept   = in_valid && in_ready;
    produce  = adv && !is_ctl;
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    cmd_d    = cmd_q;
    en_d     = en_q;
    acc_in_d = acc_in_q;
    sft_d    = sft_q;
    if (accept) begin
      s1_v_d   = 1'b1;
      cmd_d    = cmd_e'(cmd);
      en_d     = lane_en;
      acc_in_d = acc_in;
      sft_d    = sft;
    end else if (adv) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    aln_d       = aln_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < LANES; i++) begin
      logic [ExtW:0]   res;
      logic [SFTW-1:0] amt;
      int unsigned     sacc;
      amt       = sft_q[i*SFTW +: SFTW];
      res       = align_lane(acc_q[i], amt);
      sacc      = (32'(amt) > ACCW) ? ACCW : 32'(amt);
      acc_d[i]  = acc_q[i];
      if (produce) begin
        aln_d[i*ExtW +: ExtW] = en_q[i] ? res[ExtW-1:0] : '0;
        ovf_d[i]              = en_q[i] ? res[ExtW] : 1'b0;
      end
      if (adv && en_q[i]) begin
        unique case (cmd_q)
          CmdLoad:     acc_d[i] = acc_in_q[i*ACCW +: ACCW];
          CmdClear:    acc_d[i] = '0;
          CmdShiftAcc: acc_d[i] = acc_q[i] >> sacc;
          CmdAlign:    acc_d[i] = acc_q[i];
          default:     acc_d[i] = acc_q[i];
        endcase
      end
    end
    if (produce) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v_q      <= 1'b0;
      cmd_q       <= CmdLoad;
      en_q        <= '0;
      acc_in_q    <= '0;
      sft_q       <= '0;
      out_valid_q <= 1'b0;
      aln_q       <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_v_q      <= s1_v_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
      acc_in_q    <= acc_in_d;
      sft_q       <= sft_d;
      out_valid_q <= out_valid_d;
      aln_q       <= aln_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      acc_o[i*ACCW +: ACCW] = acc_q[i];
    end
  end

  assign out_valid = out_valid_q;
  assign aln       = aln_q;
  assign ovf       = ovf_q;

endmodule
